// File: rtl/instr_decode_queue_if.sv
// Handshake bundle between a decoded-instruction producer/consumer and instr_decode_queue.
// master = the side feeding instructions and taking decoded entries; slave = the queue itself.
interface instr_decode_queue_if #(
    parameter int DEPTH = 2,
    parameter int AOP_W = 6
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [AOP_W-1:0] out_aluop;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [31:0]      out_imm;
    logic             out_illegal;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_aluop, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal, count
    );

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_aluop, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal, count
    );
endinterface

// File: rtl/instr_decode_queue.sv
// RV32I instruction decoder feeding a DEPTH-entry FIFO of decoded entries.
// Define RV32M_EN to also decode the M-extension multiply/divide ops (codes 38-45).
module instr_decode_queue #(
    parameter int DEPTH = 2,
    parameter int AOP_W = 6
) (
    input logic                 clk,
    input logic                 rst_n,
    instr_decode_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam int EW = AOP_W + 1 + 15 + 32;

    typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH} fmt_t;

    logic [6:0]    w_opcode;
    logic [2:0]    w_f3;
    logic [6:0]    w_f7;
    logic [5:0]    w_code;
    fmt_t          w_fmt;
    logic [31:0]   w_imm;
    logic          w_illegal;
    logic [EW-1:0] w_entry;
    logic [EW-1:0] w_head;
    logic          w_push;
    logic          w_pop;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    assign w_opcode = bus.in_instr[6:0];
    assign w_f3     = bus.in_instr[14:12];
    assign w_f7     = bus.in_instr[31:25];

    always_comb begin
        w_code = '0;
        w_fmt  = FMT_NONE;
        case (w_opcode)
            7'b0110011: begin
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_code = 6'd1;
                        3'b001:  w_code = 6'd6;
                        3'b010:  w_code = 6'd9;
                        3'b011:  w_code = 6'd10;
                        3'b100:  w_code = 6'd3;
                        3'b101:  w_code = 6'd7;
                        3'b110:  w_code = 6'd4;
                        default: w_code = 6'd5;
                    endcase
                end else if (w_f7 == 7'b0100000) begin
                    if (w_f3 == 3'b000)      w_code = 6'd2;
                    else if (w_f3 == 3'b101) w_code = 6'd8;
                end else if (w_f7 == 7'b0000001) begin
`ifdef RV32M_EN
                    w_code = 6'd38 + {3'b000, w_f3};
`else
                    w_code = '0;
`endif
                end
            end
            7'b0010011: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'b000: w_code = 6'd11;
                    3'b010: w_code = 6'd18;
                    3'b011: w_code = 6'd19;
                    3'b100: w_code = 6'd12;
                    3'b110: w_code = 6'd13;
                    3'b111: w_code = 6'd14;
                    3'b001: begin
                        w_fmt = FMT_SH;
                        if (w_f7 == 7'b0000000) w_code = 6'd15;
                    end
                    default: begin
                        w_fmt = FMT_SH;
                        if (w_f7 == 7'b0000000)      w_code = 6'd16;
                        else if (w_f7 == 7'b0100000) w_code = 6'd17;
                    end
                endcase
            end
            7'b0000011: begin
                w_fmt = FMT_I;
                case (w_f3)
                    3'b000:  w_code = 6'd20;
                    3'b001:  w_code = 6'd21;
                    3'b010:  w_code = 6'd22;
                    3'b100:  w_code = 6'd23;
                    3'b101:  w_code = 6'd24;
                    default: w_code = '0;
                endcase
            end
            7'b1100111: begin
                w_fmt = FMT_I;
                if (w_f3 == 3'b000) w_code = 6'd25;
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                case (w_f3)
                    3'b000:  w_code = 6'd26;
                    3'b001:  w_code = 6'd27;
                    3'b010:  w_code = 6'd28;
                    default: w_code = '0;
                endcase
            end
            7'b1100011: begin
                w_fmt = FMT_B;
                case (w_f3)
                    3'b000:  w_code = 6'd29;
                    3'b001:  w_code = 6'd30;
                    3'b100:  w_code = 6'd31;
                    3'b101:  w_code = 6'd32;
                    3'b110:  w_code = 6'd33;
                    3'b111:  w_code = 6'd34;
                    default: w_code = '0;
                endcase
            end
            7'b1101111: begin w_code = 6'd35; w_fmt = FMT_J; end
            7'b0110111: begin w_code = 6'd36; w_fmt = FMT_U; end
            7'b0010111: begin w_code = 6'd37; w_fmt = FMT_U; end
            default:    w_code = '0;
        endcase
    end

    assign w_illegal = (w_code == '0);

    // Illegal words carry no immediate even if their opcode implies a format.
    always_comb begin
        w_imm = '0;
        if (!w_illegal) begin
            case (w_fmt)
                FMT_I:  w_imm = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
                FMT_S:  w_imm = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
                FMT_B:  w_imm = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                                 bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
                FMT_U:  w_imm = {bus.in_instr[31:12], 12'h000};
                FMT_J:  w_imm = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                                 bus.in_instr[20], bus.in_instr[30:21], 1'b0};
                FMT_SH: w_imm = {27'b0, bus.in_instr[24:20]};
                default: w_imm = '0;
            endcase
        end
    end

    assign w_entry = {AOP_W'(w_code), w_illegal, bus.in_instr[11:7], bus.in_instr[19:15],
                      bus.in_instr[24:20], w_imm};

    assign bus.in_ready  = (r_count < CW'(DEPTH));
    assign bus.out_valid = (r_count != '0);
    assign w_push        = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_pop         = bus.out_valid && bus.out_ready && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= w_entry;
    end

    assign w_head = bus.out_valid ? r_mem[r_rdPtr] : '0;

    assign bus.out_aluop   = w_head[EW-1 -: AOP_W];
    assign bus.out_illegal = w_head[47];
    assign bus.out_rd      = w_head[46:42];
    assign bus.out_rs1     = w_head[41:37];
    assign bus.out_rs2     = w_head[36:32];
    assign bus.out_imm     = w_head[31:0];
    assign bus.count       = r_count;
endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench for instr_decode_queue (DEPTH=2, AOP_W=6).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_decode_queue;
    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    instr_decode_queue_if #(.DEPTH(2), .AOP_W(6)) bus ();

    instr_decode_queue #(.DEPTH(2), .AOP_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive inputs for one cycle, then land on the next falling edge.
    task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                                 input logic ready, input logic fl);
        bus.in_valid  = valid;
        bus.in_instr  = instr;
        bus.out_ready = ready;
        bus.flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkHead(input string tag, input int aluop, input int illegal,
                             input int rd, input logic [31:0] imm);
        checkOutput({tag, ".valid"},   32'(bus.out_valid),   32'd1);
        checkOutput({tag, ".aluop"},   32'(bus.out_aluop),   32'(aluop));
        checkOutput({tag, ".illegal"}, 32'(bus.out_illegal), 32'(illegal));
        checkOutput({tag, ".rd"},      32'(bus.out_rd),      32'(rd));
        checkOutput({tag, ".imm"},     bus.out_imm,          imm);
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, ".count"}, 32'(bus.count),     32'd0);
        checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, ".ready"}, 32'(bus.in_ready),  32'd1);
        checkOutput({tag, ".aluop"}, 32'(bus.out_aluop), 32'd0);
        checkOutput({tag, ".imm"},   bus.out_imm,        32'd0);
        checkOutput({tag, ".rd"},    32'(bus.out_rd),    32'd0);
    endtask

    typedef struct {
        logic [31:0] instr;
        int          aluop;
        int          rd;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[$];
    int   mulAluop;
    int   mulIllegal;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst.count", 32'(bus.count),     32'd0);
        checkOutput("rst.valid", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkEmpty("afterRst");

        // add x3,x1,x2 with consumer ready: visible one edge later, then drained
        applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b0);
        checkHead("add", 1, 0, 3, 32'h0);
        checkOutput("add.rs1", 32'(bus.out_rs1), 32'd1);
        checkOutput("add.rs2", 32'(bus.out_rs2), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkEmpty("addDrain");

        // sub then slti, order preserved
        applyStimulus(1'b1, 32'h40208133, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFF02293, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("pair.count", 32'(bus.count),    32'd2);
        checkOutput("pair.ready", 32'(bus.in_ready), 32'd0);
        checkHead("sub", 2, 0, 2, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkHead("slti", 18, 0, 5, 32'hFFFFFFFF);
        checkOutput("slti.rs1", 32'(bus.out_rs1), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkEmpty("pairDrain");

        // back-pressure: third word held until the first pop frees a slot
        applyStimulus(1'b1, 32'h00000013, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40208133, 1'b0, 1'b0);
        checkOutput("full.count", 32'(bus.count),     32'd2);
        checkOutput("full.ready", 32'(bus.in_ready),  32'd0);
        checkOutput("full.head",  32'(bus.out_aluop), 32'd11);
        applyStimulus(1'b1, 32'h40208133, 1'b1, 1'b0);
        checkOutput("drain1.count", 32'(bus.count),     32'd1);
        checkOutput("drain1.head",  32'(bus.out_aluop), 32'd1);
        applyStimulus(1'b1, 32'h40208133, 1'b1, 1'b0);
        checkOutput("drain2.count", 32'(bus.count),     32'd1);
        checkOutput("drain2.head",  32'(bus.out_aluop), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkEmpty("drain3");

        // illegal word and the M-extension boundary
        applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkHead("ones", 0, 1, 31, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
`ifdef RV32M_EN
        mulAluop   = 38;
        mulIllegal = 0;
`else
        mulAluop   = 0;
        mulIllegal = 1;
`endif
        applyStimulus(1'b1, 32'h022081B3, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkHead("mul", mulAluop, mulIllegal, 3, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // immediate formats, one at a time
        vecs.push_back('{32'hFFC12283, 22, 5, 32'hFFFFFFFC});
        vecs.push_back('{32'h0030A423, 28, 8, 32'h00000008});
        vecs.push_back('{32'hFE208CE3, 29, 25, 32'hFFFFFFF8});
        vecs.push_back('{32'h123453B7, 36, 7, 32'h12345000});
        vecs.push_back('{32'h001000EF, 35, 1, 32'h00000800});
        vecs.push_back('{32'h4051D213, 17, 4, 32'h00000005});
        vecs.push_back('{32'hFFFFF117, 37, 2, 32'hFFFFF000});
        vecs.push_back('{32'h00009067, 0, 0, 32'h00000000});
        foreach (vecs[i]) begin
            applyStimulus(1'b1, vecs[i].instr, 1'b0, 1'b0);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            checkHead($sformatf("vec%0d", i), vecs[i].aluop, (vecs[i].aluop == 0) ? 1 : 0,
                      vecs[i].rd, vecs[i].imm);
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        end
        checkEmpty("vecDrain");

        // flush with push and pop requested in the same cycle
        applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40208133, 1'b0, 1'b0);
        checkOutput("preFlush.count", 32'(bus.count), 32'd2);
        applyStimulus(1'b1, 32'h00000013, 1'b1, 1'b1);
        checkEmpty("flushFull");
        applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00000013, 1'b1, 1'b1);
        checkEmpty("flushHalf");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkEmpty("postFlush");

        // asynchronous reset between edges
        applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40208133, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRst.valid", 32'(bus.out_valid), 32'd0);
        checkOutput("asyncRst.count", 32'(bus.count),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkEmpty("afterAsyncRst");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/instr_decode_queue.md
INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

Interface
REQ-001 Parameter DEPTH, default 2: decoded-entry queue depth; legal values 2, 4, 8, 16.
REQ-002 Parameter AOP_W, default 6: out_aluop width; minimum 6.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  in_instr presented.
REQ-006 in_ready  output  1  queue accepts an entry this cycle.
REQ-007 in_instr  input  32  raw RV32 instruction word.
REQ-008 flush  input  1  synchronous discard of all queued entries.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  consumer takes head entry.
REQ-011 out_aluop  output  AOP_W  operation code of head entry.
REQ-012 out_rd, out_rs1, out_rs2  output  5 each  register indices of head entry.
REQ-013 out_imm  output  32  sign-extended immediate of head entry.
REQ-014 out_illegal  output  1  head entry did not decode.
REQ-015 count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 Push when in_valid && in_ready; pop when out_valid && out_ready; both may occur in one cycle.
REQ-017 Decode is computed combinationally from in_instr and written into the queue on push; push at edge N gives out_valid=1 after edge N when queue was empty (1-cycle latency).
REQ-018 Decode key = {funct7, funct3, opcode} (17 bits); codes: add 1, sub 2, xor 3, or 4, and 5, sll 6, srl 7, sra 8, slt 9, sltu 10, addi 11, xori 12, ori 13, andi 14, slli 15, srli 16, srai 17, slti 18, sltiu 19, lb 20, lh 21, lw 22, lbu 23, lhu 24, jalr 25, sb 26, sh 27, sw 28, beq 29, bne 30, blt 31, bge 32, bltu 33, bgeu 34, jal 35, lui 36, auipc 37.
REQ-019 Key matching: R-type and shift-immediates match funct7+funct3+opcode; other I/S/B types match funct3+opcode; jalr requires funct3=000; jal, lui, auipc match opcode only.
REQ-020 slti matches funct3=010, opcode 0010011.
REQ-021 No match -> out_aluop=0, out_illegal=1; any match -> out_illegal=0.
REQ-022 out_imm per format: I = instr[31:20]; S = {instr[31:25],instr[11:7]}; B = {instr[31],instr[7],instr[30:25],instr[11:8],0}; U = {instr[31:12],12'h0}; J = {instr[31],instr[19:12],instr[20],instr[30:21],0}; all sign-extended from bit 31; R-type and illegal -> 0.
REQ-023 Shift-immediate out_imm = zero-extended instr[24:20].
REQ-024 rd/rs1/rs2 always taken from instr[11:7]/[19:15]/[24:20] regardless of format.
REQ-025 in_ready = (count < DEPTH); registered-count based, not dependent on out_ready in the same cycle.
REQ-026 Full: in_ready=0, no push even if out_ready=1 that cycle.
REQ-027 Empty: out_valid=0; all out_* data fields drive 0.
REQ-028 Read/write pointers wrap modulo DEPTH; order is strictly FIFO.
REQ-029 flush has priority: count<=0, pointers<=0, simultaneous push and pop ignored; in_ready=1 the following cycle.

Reset
REQ-030 rst_n low asynchronously clears pointers and count; out_valid=0, in_ready=1 (once rst_n deasserted), all out_* data 0.
REQ-031 Reset mid-operation discards all queued entries; no entry reappears after release.
REQ-032 Queue storage need not be reset.

Configuration
REQ-033 Macro RV32M_EN defined: funct7=0000001, opcode 0110011 decodes mul 38, mulh 39, mulhsu 40, mulhu 41, div 42, divu 43, rem 44, remu 45, out_illegal=0, out_imm=0.
REQ-034 RV32M_EN undefined: those encodings decode illegal (aluop 0, out_illegal=1).

Verification
REQ-035 Push 0x002081B3, out_ready=1 -> next cycle out_valid=1, aluop 1, rd 3, rs1 1, rs2 2, imm 0, illegal 0.
REQ-036 Push 0x40208133 then 0xFFF02293 -> sub aluop 2; slti aluop 18, rd 5, imm 0xFFFFFFFF, order preserved.
REQ-037 DEPTH=2, out_ready=0, push 3 instructions back-to-back -> count=2, in_ready=0, third held; raise out_ready -> heads drain in order, third accepted after first pop.
REQ-038 Push 0xFFFFFFFF -> aluop 0, illegal 1, imm 0; push 0x022081B3 -> aluop 38 with RV32M_EN, illegal without.
REQ-039 Queue holding 2 entries, flush with in_valid=1 and out_ready=1 same cycle -> next cycle count=0, out_valid=0, in_ready=1, nothing pushed.
REQ-040 rst_n pulsed low mid-stream between edges -> out_valid=0 and count=0 immediately, before next clk edge.
